// File: rtl/control_rana.sv
// control_rana -- frog movement / game-state controller.
//
// Moves the frog over an 8x8 board from button edges, detects collisions with
// the obstacle row under the frog, handles arrival at the house row, deaths,
// lives/houses bookkeeping and the end-of-game / restart handshake.
//
// Optional feature: define CR_TIMEOUT_EN to enable a per-life time limit of
// TIEMPO_VIDA cycles in JUGANDO. Without it JUGANDO has no time limit.
//
// Ports:
//   CR_CLOCK_50    clock, rising edge
//   CR_RESET       asynchronous reset, active low
//   CR_UP_IN, CR_DOWN_IN, CR_LEFT_IN, CR_RIGHT_IN   button levels (1 = pressed)
//   CR_OBST_IN     obstacle row at CR_POSY_OUT, bit 7-X set = column X occupied
//   CR_TOP_IN      house row, bit 7-X clear = free house at column X
//   CR_POSX_OUT    frog column (registered)
//   CR_POSY_OUT    frog row (registered), 0 = start, 7 = houses
//   CR_ESTADO_OUT  state code (registered)
//   CR_PERDIO_OUT  one-cycle board-clear pulse on FIN/GANO -> INICIO
//   CR_VIDAS_OUT   lives remaining
//   CR_CASAS_OUT   houses filled this game
module control_rana #(
  parameter int unsigned DATAWIDTH_POS    = 3,
  parameter int unsigned DATAWIDTH_ESTADO = 3,
  parameter int unsigned DATAWIDTH_BUS    = 8,
  parameter int unsigned VIDAS_INIT       = 3,
  parameter int unsigned T_MUERTE         = 25000000,
  parameter int unsigned TIEMPO_VIDA      = 500000000
) (
  input  logic                        CR_CLOCK_50,
  input  logic                        CR_RESET,
  input  logic                        CR_UP_IN,
  input  logic                        CR_DOWN_IN,
  input  logic                        CR_LEFT_IN,
  input  logic                        CR_RIGHT_IN,
  input  logic [DATAWIDTH_BUS-1:0]    CR_OBST_IN,
  input  logic [DATAWIDTH_BUS-1:0]    CR_TOP_IN,
  output logic [DATAWIDTH_POS-1:0]    CR_POSX_OUT,
  output logic [DATAWIDTH_POS-1:0]    CR_POSY_OUT,
  output logic [DATAWIDTH_ESTADO-1:0] CR_ESTADO_OUT,
  output logic                        CR_PERDIO_OUT,
  output logic [1:0]                  CR_VIDAS_OUT,
  output logic [1:0]                  CR_CASAS_OUT
);

  typedef enum logic [2:0] {
    StInicio  = 3'b000,
    StJugando = 3'b001,
    StMuerto  = 3'b010,
    StFin     = 3'b011,
    StGano    = 3'b100,
    StLlego   = 3'b111
  } estado_e;

  // Board is square: last column index equals the house row index.
  localparam logic [DATAWIDTH_POS-1:0] POS_MAX    = DATAWIDTH_POS'(DATAWIDTH_BUS - 1);
  localparam logic [DATAWIDTH_POS-1:0] Y_ULTIMA   = DATAWIDTH_POS'(DATAWIDTH_BUS - 2);
  localparam logic [DATAWIDTH_POS-1:0] X_INICIO   = DATAWIDTH_POS'(3);
  localparam int unsigned              MW         = (T_MUERTE > 1) ? $clog2(T_MUERTE) : 1;
  localparam logic [MW-1:0]            MUERTE_FIN = MW'(T_MUERTE - 1);
  localparam logic [1:0]               VIDAS_RST  = 2'(VIDAS_INIT);

  estado_e                  estado_q, estado_d;
  logic [DATAWIDTH_POS-1:0] pos_x_q, pos_x_d;
  logic [DATAWIDTH_POS-1:0] pos_y_q, pos_y_d;
  logic [1:0]               vidas_q, vidas_d;
  logic [1:0]               casas_q, casas_d;
  logic                     perdio_q, perdio_d;
  logic [MW-1:0]            muerte_q, muerte_d;
  logic [3:0]               btn_q;
  logic                     armado_q;

  logic [3:0]               btn;
  logic [3:0]               pedido;
  logic                     hay_pedido;
  logic [DATAWIDTH_POS-1:0] col;
  logic                     choque;
  logic                     casa_libre;
  logic                     muere;

`ifdef CR_TIMEOUT_EN
  logic [31:0] vida_q, vida_d;
  logic        vida_agotada;
  assign vida_agotada = (vida_q == 32'(TIEMPO_VIDA - 1));
`endif

  // Bit order {up, down, left, right} doubles as the move priority.
  assign btn = {CR_UP_IN, CR_DOWN_IN, CR_LEFT_IN, CR_RIGHT_IN};
  // armado_q stays low for the first cycle after reset so a button held
  // across reset release loads btn_q without producing an edge.
  assign pedido     = armado_q ? (btn & ~btn_q) : 4'b0000;
  assign hay_pedido = |pedido;
  assign col        = POS_MAX - pos_x_q;
  assign choque     = (pos_y_q != '0) && (pos_y_q <= Y_ULTIMA) && CR_OBST_IN[col];
  assign casa_libre = ~CR_TOP_IN[col];
`ifdef CR_TIMEOUT_EN
  assign muere      = choque || vida_agotada;
`else
  assign muere      = choque;
`endif

  always_comb begin
    estado_d = estado_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vidas_d  = vidas_q;
    casas_d  = casas_q;
    perdio_d = 1'b0;
    muerte_d = muerte_q;
`ifdef CR_TIMEOUT_EN
    vida_d   = vida_q;
`endif
    case (estado_q)
      StInicio: begin
        pos_x_d = X_INICIO;
        pos_y_d = '0;
        if (hay_pedido) begin
          estado_d = StJugando;
          vidas_d  = VIDAS_RST;
          casas_d  = 2'd0;
`ifdef CR_TIMEOUT_EN
          vida_d   = '0;
`endif
        end
      end
      StJugando: begin
`ifdef CR_TIMEOUT_EN
        vida_d = vida_q + 32'd1;
`endif
        if (muere) begin
          estado_d = StMuerto;
          vidas_d  = (vidas_q == 2'd0) ? 2'd0 : vidas_q - 2'd1;
          muerte_d = '0;
        end else if (pedido[3]) begin
          if (pos_y_q != Y_ULTIMA) begin
            pos_y_d = pos_y_q + 1'b1;
          end else if (casa_libre) begin
            pos_y_d  = POS_MAX;
            estado_d = StLlego;
            casas_d  = (casas_q == 2'd3) ? 2'd3 : casas_q + 2'd1;
          end
        end else if (pedido[2]) begin
          if (pos_y_q != '0) pos_y_d = pos_y_q - 1'b1;
        end else if (pedido[1]) begin
          if (pos_x_q != '0) pos_x_d = pos_x_q - 1'b1;
        end else if (pedido[0]) begin
          if (pos_x_q != POS_MAX) pos_x_d = pos_x_q + 1'b1;
        end
      end
      StLlego: begin
        // casas_q already includes this arrival.
        if (casas_q == 2'd3) begin
          estado_d = StGano;
        end else begin
          estado_d = StJugando;
          pos_x_d  = X_INICIO;
          pos_y_d  = '0;
`ifdef CR_TIMEOUT_EN
          vida_d   = '0;
`endif
        end
      end
      StMuerto: begin
        if (muerte_q == MUERTE_FIN) begin
          if (vidas_q == 2'd0) begin
            estado_d = StFin;
          end else begin
            estado_d = StJugando;
            pos_x_d  = X_INICIO;
            pos_y_d  = '0;
`ifdef CR_TIMEOUT_EN
            vida_d   = '0;
`endif
          end
        end else begin
          muerte_d = muerte_q + 1'b1;
        end
      end
      StFin, StGano: begin
        if (hay_pedido) begin
          estado_d = StInicio;
          perdio_d = 1'b1;
          pos_x_d  = X_INICIO;
          pos_y_d  = '0;
        end
      end
      default: begin
        estado_d = StInicio;
        pos_x_d  = X_INICIO;
        pos_y_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CR_CLOCK_50 or negedge CR_RESET) begin
    if (!CR_RESET) begin
      estado_q <= StInicio;
      pos_x_q  <= X_INICIO;
      pos_y_q  <= '0;
      vidas_q  <= VIDAS_RST;
      casas_q  <= 2'd0;
      perdio_q <= 1'b0;
      muerte_q <= '0;
      btn_q    <= 4'b0000;
      armado_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vidas_q  <= vidas_d;
      casas_q  <= casas_d;
      perdio_q <= perdio_d;
      muerte_q <= muerte_d;
      btn_q    <= btn;
      armado_q <= 1'b1;
    end
  end

`ifdef CR_TIMEOUT_EN
  always_ff @(posedge CR_CLOCK_50 or negedge CR_RESET) begin
    if (!CR_RESET) begin
      vida_q <= '0;
    end else begin
      vida_q <= vida_d;
    end
  end
`endif

  assign CR_POSX_OUT   = pos_x_q;
  assign CR_POSY_OUT   = pos_y_q;
  assign CR_ESTADO_OUT = DATAWIDTH_ESTADO'(estado_q);
  assign CR_PERDIO_OUT = perdio_q;
  assign CR_VIDAS_OUT  = vidas_q;
  assign CR_CASAS_OUT  = casas_q;

endmodule

// File: tb/tb_control_rana.sv
module tb_control_rana;

  localparam int T_M = 4;
  localparam int T_V = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [7:0] obst = 8'h00;
  logic [7:0] top = 8'hFF;
  logic [2:0] posx, posy, estado;
  logic       perdio;
  logic [1:0] vidas, casas;

  always #5 clk = ~clk;

  control_rana #(
    .DATAWIDTH_POS   (3),
    .DATAWIDTH_ESTADO(3),
    .DATAWIDTH_BUS   (8),
    .VIDAS_INIT      (3),
    .T_MUERTE        (T_M),
    .TIEMPO_VIDA     (T_V)
  ) dut (
    .CR_CLOCK_50  (clk),
    .CR_RESET     (rst_n),
    .CR_UP_IN     (up),
    .CR_DOWN_IN   (down),
    .CR_LEFT_IN   (left),
    .CR_RIGHT_IN  (right),
    .CR_OBST_IN   (obst),
    .CR_TOP_IN    (top),
    .CR_POSX_OUT  (posx),
    .CR_POSY_OUT  (posy),
    .CR_ESTADO_OUT(estado),
    .CR_PERDIO_OUT(perdio),
    .CR_VIDAS_OUT (vidas),
    .CR_CASAS_OUT (casas)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Game model: state codes as plain ints, hold time as a countdown.
  int       m_st = 0, m_x = 3, m_y = 0, m_vidas = 3, m_casas = 0, m_perdio = 0;
  int       m_hold = 0, m_life = 0;
  bit [3:0] m_prev = 4'b0;
  bit       m_armed = 0;

  task automatic m_reset();
    m_st = 0; m_x = 3; m_y = 0; m_vidas = 3; m_casas = 0; m_perdio = 0;
    m_hold = 0; m_life = 0; m_prev = 4'b0; m_armed = 0;
  endtask

  task automatic m_step();
    bit [3:0] b;
    bit [3:0] r;
    bit       expired;
    b = {up, down, left, right};
    r = m_armed ? (b & ~m_prev) : 4'b0;
    m_prev = b;
    m_armed = 1;
    m_perdio = 0;
    expired = 0;
    case (m_st)
      0: begin
        m_x = 3; m_y = 0;
        if (r != 0) begin m_st = 1; m_vidas = 3; m_casas = 0; m_life = 0; end
      end
      1: begin
`ifdef CR_TIMEOUT_EN
        m_life++;
        expired = (m_life >= T_V);
`endif
        if ((m_y >= 1 && m_y <= 6 && obst[7 - m_x]) || expired) begin
          m_st = 2; m_vidas = (m_vidas > 0) ? m_vidas - 1 : 0; m_hold = T_M;
        end else if (r[3]) begin
          if (m_y < 6) m_y++;
          else if (!top[7 - m_x]) begin
            m_y = 7; m_st = 7; m_casas = (m_casas < 3) ? m_casas + 1 : 3;
          end
        end else if (r[2]) begin
          if (m_y > 0) m_y--;
        end else if (r[1]) begin
          if (m_x > 0) m_x--;
        end else if (r[0]) begin
          if (m_x < 7) m_x++;
        end
      end
      2: begin
        m_hold--;
        if (m_hold == 0) begin
          if (m_vidas == 0) m_st = 3;
          else begin m_st = 1; m_x = 3; m_y = 0; m_life = 0; end
        end
      end
      7: begin
        if (m_casas >= 3) m_st = 4;
        else begin m_st = 1; m_x = 3; m_y = 0; m_life = 0; end
      end
      3, 4: begin
        if (r != 0) begin m_st = 0; m_perdio = 1; m_x = 3; m_y = 0; end
      end
      default: m_st = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] act, exp;
      act = {estado, posx, posy, perdio, vidas, casas};
      exp = {3'(m_st), 3'(m_x), 3'(m_y), 1'(m_perdio), 2'(m_vidas), 2'(m_casas)};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL cycle t=%0t st/x/y/perdio/vidas/casas got %0d/%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d/%0d",
                 $time, estado, posx, posy, perdio, vidas, casas,
                 m_st, m_x, m_y, m_perdio, m_vidas, m_casas);
      end
    end
  end

  // Hand-computed expectation.
  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] v);
    {up, down, left, right} = v;
  endtask

  // Press for one cycle; returns on the negedge after the move was taken.
  task automatic pulse(input logic [3:0] v);
    @(negedge clk);
    set_btn(v);
    @(negedge clk);
    set_btn(4'b0000);
  endtask

  task automatic pulse_n(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) pulse(v);
  endtask

  localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001;

  // Expects the bench to sit at a negedge with the DUT inside a MUERTO hold.
  task automatic reset_in_hold();
    lit("in_hold_state", int'(estado), 2);
    #2 rst_n = 1'b0;
    #1;
    lit("async_rst_state", int'(estado), 0);
    lit("async_rst_vidas", int'(vidas), 3);
    lit("async_rst_perdio", int'(perdio), 0);
    lit("async_rst_x", int'(posx), 3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    lit("after_rst_state", int'(estado), 0);
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1;
    lit("rst_state", int'(estado), 0);
    lit("rst_x", int'(posx), 3);
    lit("rst_y", int'(posy), 0);
    lit("rst_vidas", int'(vidas), 3);
    lit("rst_casas", int'(casas), 0);
    lit("rst_perdio", int'(perdio), 0);
    // Button held across reset release gives no move request.
    up = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    lit("held_btn_no_start", int'(estado), 0);
    up = 1'b0;

    pulse(U);
    lit("start_state", int'(estado), 1);
    lit("start_x", int'(posx), 3);
    lit("start_y", int'(posy), 0);

`ifndef CR_TIMEOUT_EN
    pulse(U); pulse(R); pulse(R);
    lit("move_x", int'(posx), 5);
    lit("move_y", int'(posy), 1);

    pulse_n(L, 2);
    // UP and LEFT together: only UP, and holding gives nothing more.
    @(negedge clk);
    set_btn(U | L);
    repeat (10) @(negedge clk);
    set_btn(4'b0000);
    lit("prio_x", int'(posx), 3);
    lit("prio_y", int'(posy), 2);

    pulse_n(L, 2);
    pulse_n(U, 4);
    lit("at_16_y", int'(posy), 6);
    top = 8'b10110101;
    pulse(U);
    lit("llego_state", int'(estado), 7);
    lit("llego_x", int'(posx), 1);
    lit("llego_y", int'(posy), 7);
    lit("llego_casas", int'(casas), 1);
    @(negedge clk);
    lit("post_llego_state", int'(estado), 1);
    lit("post_llego_y", int'(posy), 0);

    pulse_n(L, 3);
    pulse_n(U, 6);
    pulse(U);
    lit("blocked_house_y", int'(posy), 6);
    lit("blocked_house_st", int'(estado), 1);
    top = 8'hFF;

    // Death 1 at (2,3).
    pulse_n(D, 3);
    pulse_n(R, 2);
    @(negedge clk);
    obst = 8'b00100000;
    @(negedge clk);
    obst = 8'h00;
    lit("death1_state", int'(estado), 2);
    lit("death1_vidas", int'(vidas), 2);
    repeat (4) @(negedge clk);
    lit("revive_state", int'(estado), 1);
    lit("revive_x", int'(posx), 3);

    // Death 2: collision beats a simultaneous UP.
    pulse(U);
    @(negedge clk);
    obst = 8'b00010000;
    up = 1'b1;
    @(negedge clk);
    obst = 8'h00;
    up = 1'b0;
    lit("death2_state", int'(estado), 2);
    lit("death2_y", int'(posy), 1);
    repeat (4) @(negedge clk);

    // Death 3 -> FIN.
    pulse(U);
    @(negedge clk);
    obst = 8'b00010000;
    @(negedge clk);
    obst = 8'h00;
    lit("death3_vidas", int'(vidas), 0);
    repeat (4) @(negedge clk);
    lit("fin_state", int'(estado), 3);
    repeat (3) @(negedge clk);
    lit("fin_holds", int'(estado), 3);
    pulse(R);
    lit("fin_perdio", int'(perdio), 1);
    lit("fin_to_inicio", int'(estado), 0);
    @(negedge clk);
    lit("perdio_drop", int'(perdio), 0);

    // Three houses -> GANO.
    pulse(U);
    lit("game2_vidas", int'(vidas), 3);
    lit("game2_casas", int'(casas), 0);
    top = 8'b11101111;
    for (int h = 0; h < 3; h++) begin
      pulse_n(U, 7);
      @(negedge clk);
    end
    lit("gano_state", int'(estado), 4);
    lit("gano_casas", int'(casas), 3);
    top = 8'hFF;
    pulse(D);
    lit("gano_perdio", int'(perdio), 1);
    lit("gano_to_inicio", int'(estado), 0);

    // No time limit in this build.
    pulse(U);
    repeat (100) @(negedge clk);
    lit("idle_100", int'(estado), 1);

    // Reset in the middle of a death hold.
    pulse(U);
    @(negedge clk);
    obst = 8'b00010000;
    @(negedge clk);
    obst = 8'h00;
    @(negedge clk);
    reset_in_hold();
`else
    repeat (19) @(negedge clk);
    lit("timeout_not_yet", int'(estado), 1);
    @(negedge clk);
    lit("timeout_state", int'(estado), 2);
    lit("timeout_vidas", int'(vidas), 2);
    @(negedge clk);
    reset_in_hold();
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_rana.md
CONTROL_RANA -- requirements
Module: control_rana

Interface
REQ-001 Parameter DATAWIDTH_POS, default 3, width of the position buses.
REQ-002 Parameter DATAWIDTH_ESTADO, default 3, width of the state code.
REQ-003 Parameter DATAWIDTH_BUS, default 8, width of the row buses.
REQ-004 Parameter VIDAS_INIT, default 3, lives at game start (1..3).
REQ-005 Parameter T_MUERTE, default 25000000, death-hold duration in clock cycles (>=1).
REQ-006 Parameter TIEMPO_VIDA, default 500000000, per-life time limit in cycles (used only under REQ-030).
REQ-007 CR_CLOCK_50 input 1: the single clock; all flops on its rising edge.
REQ-008 CR_RESET input 1: reset, asynchronous, active-low.
REQ-009 CR_UP_IN, CR_DOWN_IN, CR_LEFT_IN, CR_RIGHT_IN inputs 1 each: synchronous button levels, 1 = pressed.
REQ-010 CR_OBST_IN input 8: obstacle row at CR_POSY_OUT; bit 7-X = 1 means column X is occupied.
REQ-011 CR_TOP_IN input 8: house row (row 7) from the house-control stage; bit 7-X = 0 means a free house at column X.
REQ-012 CR_POSX_OUT, CR_POSY_OUT output 3 each: registered frog column/row; row 0 = start, row 7 = houses.
REQ-013 CR_ESTADO_OUT output 3: registered state code (REQ-017).
REQ-014 CR_PERDIO_OUT output 1: registered one-cycle board-clear pulse.
REQ-015 CR_VIDAS_OUT output 2: lives remaining; CR_CASAS_OUT output 2: houses filled this game.

Function
REQ-016 A move request is the rising edge of a button; each button is registered one cycle for edge detection; a held button gives exactly one move.
REQ-017 States and codes: INICIO 000, JUGANDO 001, MUERTO 010, FIN 011, GANO 100, LLEGO 111.
REQ-018 INICIO: position (3,0); any move request -> JUGANDO, lives=VIDAS_INIT, houses=0; the request itself does not move the frog.
REQ-019 JUGANDO: at most one move per cycle; simultaneous requests use priority UP > DOWN > LEFT > RIGHT; lower-priority requests in that cycle are dropped.
REQ-020 Moves saturate: LEFT at X=0, RIGHT at X=7, DOWN at Y=0 leave the position unchanged.
REQ-021 UP at Y=6: if CR_TOP_IN[7-X]==0, the frog moves to Y=7 and the state goes to LLEGO; otherwise the position is unchanged.
REQ-022 JUGANDO with 1<=Y<=6 and CR_OBST_IN[7-X]==1 -> MUERTO; collision takes precedence over any move request in the same cycle.
REQ-023 LLEGO lasts exactly one cycle at (X,7); houses increment; the next state is GANO if houses reach 3, otherwise JUGANDO at (3,0).
REQ-024 MUERTO: lives decrement on entry and a hold counter runs T_MUERTE cycles; the state then goes to FIN if lives==0, otherwise JUGANDO at (3,0); buttons are ignored.
REQ-025 FIN/GANO: the state holds; any move request -> INICIO with CR_PERDIO_OUT=1 for exactly that transition cycle; otherwise CR_PERDIO_OUT=0.
REQ-026 Counters never wrap: lives floor at 0, houses ceiling at 3.

Reset
REQ-027 CR_RESET low asynchronously forces INICIO, position (3,0), lives=VIDAS_INIT, houses=0, CR_PERDIO_OUT=0, edge registers=0, and all timers to 0, including mid-game or mid-hold.
REQ-028 After reset release, a button already held does not generate a move request.

Configuration
REQ-029 Macro CR_TIMEOUT_EN selects the per-life time limit.
REQ-030 With CR_TIMEOUT_EN defined: a life timer clears on each entry to JUGANDO and counts in JUGANDO; reaching TIEMPO_VIDA -> MUERTO; collision in the same cycle gives the same result.
REQ-031 Without CR_TIMEOUT_EN: no life timer exists and JUGANDO has no time limit.

Verification (T_MUERTE=4, TIEMPO_VIDA=20)
REQ-032 Reset, then pulse UP -> ESTADO=001, pos (3,0); pulse UP, RIGHT, RIGHT -> pos (5,1).
REQ-033 UP and LEFT rise in the same cycle at (3,1) -> pos (3,2) only; holding both 10 cycles gives no further move.
REQ-034 At (1,6) with CR_TOP_IN=8'b10110101, pulse UP -> one cycle ESTADO=111 at (1,7), houses=1, then (3,0) in state 001; at (0,6) the same UP does not move the frog.
REQ-035 At (2,3) drive CR_OBST_IN=8'b00100000 -> ESTADO=010, lives 3->2; 4 cycles later state 001 at (3,0); three deaths -> 011; a button press then gives PERDIO=1 for one cycle and state 000.
REQ-036 CR_TIMEOUT_EN defined, idle in JUGANDO 20 cycles -> MUERTO; undefined, 100 idle cycles -> still 001.
REQ-037 Assert CR_RESET low during MUERTO hold -> immediately 000, lives=3, PERDIO=0.
